// File: rtl/udp_tx_stream_arbiter_if.sv
// udp_tx_stream_arbiter_if: UDP TX hdr + data channel bundle, N lanes wide.
//   hdr_val/hdr_rdy, src_ip, dst_ip, data_len, timestamp          header channel
//   data_val/data_rdy, data, data_last, data_padbytes              data channel
//   master drives val/payload and samples rdy; slave the reverse.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif
`ifndef TRACKER_STATS_W
`define TRACKER_STATS_W 64
`endif

interface udp_tx_stream_arbiter_if #(parameter int N = 1);
    logic [N-1:0]                        hdr_val;
    logic [N-1:0]                        hdr_rdy;
    logic [N-1:0][`IP_ADDR_W-1:0]        src_ip;
    logic [N-1:0][`IP_ADDR_W-1:0]        dst_ip;
    logic [N-1:0][`TOT_LEN_W-1:0]        data_len;
    logic [N-1:0][`TRACKER_STATS_W-1:0]  timestamp;
    logic [N-1:0]                        data_val;
    logic [N-1:0]                        data_rdy;
    logic [N-1:0][`MAC_INTERFACE_W-1:0]  data;
    logic [N-1:0]                        data_last;
    logic [N-1:0][`MAC_PADBYTES_W-1:0]   data_padbytes;

    modport master (
        output hdr_val, src_ip, dst_ip, data_len, timestamp,
        output data_val, data, data_last, data_padbytes,
        input  hdr_rdy, data_rdy
    );
    modport slave (
        input  hdr_val, src_ip, dst_ip, data_len, timestamp,
        input  data_val, data, data_last, data_padbytes,
        output hdr_rdy, data_rdy
    );
endinterface

// File: rtl/udp_tx_stream_arbiter.sv
// udp_tx_stream_arbiter: packet-granular round-robin share of one UDP TX hdr+data port.
//   clk, rst     clock, synchronous active-high reset
//   src          slave bundle, NUM_SRCS lanes from the checksum controllers
//   dst          master bundle, 1 lane towards udp_to_stream
//   pkt_cnt      per-source released-packet counters, only with UDP_TX_ARB_STATS_EN
module udp_tx_stream_arbiter #(
    parameter int NUM_SRCS = 2,
    localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
    input logic clk,
    input logic rst,
    udp_tx_stream_arbiter_if.slave src,
    udp_tx_stream_arbiter_if.master dst
`ifdef UDP_TX_ARB_STATS_EN
    ,
    output logic [NUM_SRCS-1:0][15:0] pkt_cnt
`endif
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d, rr_q, rr_d, pick, idx;
    logic                hdr_done_q, hdr_done_d, data_done_q, data_done_d;
    logic                locked, hdr_open, data_open, hdr_hs, last_hs, release_pkt;
    logic [NUM_SRCS-1:0] grant_oh;

    // descending scan so the lowest offset from rr_q wins
    always_comb begin
        pick = rr_q;
        idx = '0;
        for (int i = NUM_SRCS - 1; i >= 0; i--) begin
            idx = SRC_W'((int'(rr_q) + i) % NUM_SRCS);
            pick = src.hdr_val[idx] ? idx : pick;
        end
    end

    // rst gates the grant combinationally so a mid-packet reset drops it at once
    assign locked    = (state_q == LOCKED) && !rst;
    assign hdr_open  = locked && !hdr_done_q;
    assign data_open = locked && !data_done_q;
    assign grant_oh  = NUM_SRCS'(1) << grant_q;

    assign dst.hdr_val[0]       = hdr_open && src.hdr_val[grant_q];
    assign dst.src_ip[0]        = hdr_open ? src.src_ip[grant_q] : '0;
    assign dst.dst_ip[0]        = hdr_open ? src.dst_ip[grant_q] : '0;
    assign dst.data_len[0]      = hdr_open ? src.data_len[grant_q] : '0;
    assign dst.timestamp[0]     = hdr_open ? src.timestamp[grant_q] : '0;
    assign dst.data_val[0]      = data_open && src.data_val[grant_q];
    assign dst.data[0]          = data_open ? src.data[grant_q] : '0;
    assign dst.data_last[0]     = data_open && src.data_last[grant_q];
    assign dst.data_padbytes[0] = data_open ? src.data_padbytes[grant_q] : '0;
    assign src.hdr_rdy          = (hdr_open && dst.hdr_rdy[0]) ? grant_oh : '0;
    assign src.data_rdy         = (data_open && dst.data_rdy[0]) ? grant_oh : '0;

    assign hdr_hs      = dst.hdr_val[0] && dst.hdr_rdy[0];
    assign last_hs     = dst.data_val[0] && dst.data_rdy[0] && dst.data_last[0];
    assign release_pkt = locked && (hdr_done_q || hdr_hs) && (data_done_q || last_hs);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d = rr_q;
        hdr_done_d = hdr_done_q || hdr_hs;
        data_done_d = data_done_q || last_hs;
        if (state_q == IDLE && |src.hdr_val) begin
            state_d = LOCKED;
            grant_d = pick;
        end
        if (release_pkt) begin
            state_d = IDLE;
            hdr_done_d = 1'b0;
            data_done_d = 1'b0;
            rr_d = (grant_q == SRC_W'(NUM_SRCS - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q <= '0;
            hdr_done_q <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q <= rr_d;
            hdr_done_q <= hdr_done_d;
            data_done_q <= data_done_d;
        end
    end

`ifdef UDP_TX_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) pkt_cnt <= '0;
        else if (release_pkt) pkt_cnt[grant_q] <= pkt_cnt[grant_q] + 16'd1;
    end
`endif
endmodule
